// File: rtl/seq_subdiv_unit.sv
// Sequential subtract / restoring-divide unit with start/done handshake.
// Result word: MSB = flag (negative or divide-by-zero), low WIDTH bits = magnitude or quotient.
module seq_subdiv_unit #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     div_b_q, div_b_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic                 err_q, err_d;

    logic [WIDTH:0]       sub_diff_s;
    logic                 sub_neg_s;
    logic [WIDTH-1:0]     sub_mag_s;
    logic [WIDTH:0]       shift_s;
    logic [WIDTH:0]       trial_s;
    logic [WIDTH-1:0]     step_rem_s;
    logic [WIDTH-1:0]     step_quo_s;

    // Next-state, datapath step and output-register updates
    always_comb begin
        state_d     = state_q;
        div_b_d     = div_b_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        err_d       = err_q;

        sub_diff_s = {1'b0, a} - {1'b0, b};
        sub_neg_s  = sub_diff_s[WIDTH];
        if (sub_neg_s) begin
            sub_mag_s = b - a;
        end else begin
            sub_mag_s = a - b;
        end

        // A negative trial can only occur when the shifted remainder's top bit is clear,
        // so truncating shift_s on restore loses nothing.
        shift_s = {rem_q, quo_q[WIDTH-1]};
        trial_s = shift_s - {1'b0, div_b_q};
        if (!trial_s[WIDTH]) begin
            step_rem_s = trial_s[WIDTH-1:0];
            step_quo_s = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem_s = shift_s[WIDTH-1:0];
            step_quo_s = {quo_q[WIDTH-2:0], 1'b0};
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (!mode) begin
                        state_d     = S_DONE;
                        result_d    = {sub_neg_s, {(WIDTH-1){1'b0}}, sub_mag_s};
                        remainder_d = {WIDTH{1'b0}};
                        err_d       = 1'b0;
                    end else if (b == {WIDTH{1'b0}}) begin
                        state_d     = S_DONE;
                        result_d    = {1'b1, {(2*WIDTH-1){1'b0}}};
                        remainder_d = a;
                        err_d       = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        div_b_d = b;
                        rem_d   = {WIDTH{1'b0}};
                        quo_d   = a;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d     = S_DONE;
                    result_d    = {1'b0, {(WIDTH-1){1'b0}}, step_quo_s};
                    remainder_d = step_rem_s;
                    err_d       = 1'b0;
                end else begin
                    state_d = S_CALC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_b_q     <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= {(2*WIDTH){1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_b_q     <= div_b_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign remainder = remainder_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_subdiv_unit.sv
// Directed bench for seq_subdiv_unit (WIDTH=7): subtract, divide, divide-by-zero,
// ignored start during CALC, back-to-back start in DONE, and reset mid-division.
module tb_seq_subdiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [6:0]  a;
    logic [6:0]  b;
    logic        busy;
    logic        done;
    logic [13:0] result;
    logic [6:0]  remainder;
    logic        err;

    int checks;
    int errors;
    int n;
    int bc;
    int seen_done;

    seq_subdiv_unit #(.WIDTH(7), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one request for a single edge; returns right after the sampling edge.
    task automatic op(input logic m, input logic [6:0] aa, input logic [6:0] bb);
        start = 1'b1;
        mode  = m;
        a     = aa;
        b     = bb;
        tick();
        start = 1'b0;
    endtask

    // n counts edges since the sampling edge (already 1 on entry); bounded wait.
    task automatic wait_done();
        n  = 1;
        bc = 0;
        while (!done && n < 20) begin
            if (busy) bc++;
            tick();
            n++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        a      = 7'd0;
        b      = 7'd0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {18'd0, result}, 32'h0);
        chk("rst_rem", {25'd0, remainder}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        tick();

        // Subtract 5-9: negative flag, magnitude 4
        op(1'b0, 7'd5, 7'd9);
        chk("sub1_done", {31'd0, done}, 32'd1);
        chk("sub1_result", {18'd0, result}, 32'h2004);
        chk("sub1_rem", {25'd0, remainder}, 32'd0);
        chk("sub1_err", {31'd0, err}, 32'd0);
        tick();
        chk("sub1_done_pulse", {31'd0, done}, 32'd0);
        chk("sub1_hold", {18'd0, result}, 32'h2004);

        op(1'b0, 7'd9, 7'd5);
        chk("sub2_result", {18'd0, result}, 32'h0004);
        tick();
        op(1'b0, 7'd0, 7'd127);
        chk("sub3_result", {18'd0, result}, 32'h207F);
        tick();
        op(1'b0, 7'd64, 7'd64);
        chk("sub4_result", {18'd0, result}, 32'h0000);
        tick();

        // Divide 100/7
        op(1'b1, 7'd100, 7'd7);
        wait_done();
        chk("div1_latency", n, 32'd8);
        chk("div1_busy_cycles", bc, 32'd7);
        chk("div1_result", {18'd0, result}, 32'h000E);
        chk("div1_rem", {25'd0, remainder}, 32'd2);
        chk("div1_err", {31'd0, err}, 32'd0);
        tick();

        op(1'b1, 7'd127, 7'd1);
        wait_done();
        chk("div2_latency", n, 32'd8);
        chk("div2_result", {18'd0, result}, 32'h007F);
        chk("div2_rem", {25'd0, remainder}, 32'd0);
        tick();

        // Divide by zero, then a normal subtract clears err
        op(1'b1, 7'd5, 7'd0);
        chk("dbz_done", {31'd0, done}, 32'd1);
        chk("dbz_result", {18'd0, result}, 32'h2000);
        chk("dbz_err", {31'd0, err}, 32'd1);
        chk("dbz_rem", {25'd0, remainder}, 32'd5);
        tick();
        op(1'b0, 7'd3, 7'd1);
        chk("after_dbz_err", {31'd0, err}, 32'd0);
        chk("after_dbz_result", {18'd0, result}, 32'h0002);
        tick();

        // Start during CALC is ignored
        op(1'b1, 7'd100, 7'd7);
        tick();
        start = 1'b1;
        mode  = 1'b0;
        a     = 7'd1;
        b     = 7'd2;
        tick();
        start = 1'b0;
        a     = 7'd33;
        b     = 7'd3;
        chk("ign_busy", {31'd0, busy}, 32'd1);
        n = 3;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("ign_latency", n, 32'd8);
        chk("ign_result", {18'd0, result}, 32'h000E);
        chk("ign_rem", {25'd0, remainder}, 32'd2);

        // Back-to-back start in the DONE cycle: 50/5
        op(1'b1, 7'd50, 7'd5);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_hold", {18'd0, result}, 32'h000E);
        wait_done();
        chk("b2b_latency", n, 32'd8);
        chk("b2b_result", {18'd0, result}, 32'h000A);
        chk("b2b_rem", {25'd0, remainder}, 32'd0);
        tick();

        // Reset in the 4th CALC cycle discards the division
        op(1'b1, 7'd100, 7'd7);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_result", {18'd0, result}, 32'h0);
        chk("mid_rst_rem", {25'd0, remainder}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) seen_done = 1;
        end
        chk("mid_rst_no_done", seen_done, 32'd0);
        op(1'b0, 7'd9, 7'd5);
        chk("post_rst_done", {31'd0, done}, 32'd1);
        chk("post_rst_result", {18'd0, result}, 32'h0004);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
